gdp: RTL and testbench

- Generic deparser. It is the transmit-side counterpart of the packet parser.
- It accepts three upstream streams: the 256-bit metadata (MD) word, the 1024-bit packet header vector (PHV), and the buffered 134-bit packet-word stream from the data cache.
- It rebuilds each packet as follows: MD goes into words 0–1, PHV goes into words 2–9, and the original payload words follow.
- It emits the result on the 134-bit pktout interface towards the port/CPU side, with ready-based backpressure.

---
 rtl/gdp.sv | 153 +++++++++++++++
 tb/tb_gdp.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gdp.sv
// gdp: generic deparser, rebuilds packets as MD (words 0-1), PHV (words 2-9), then payload
// Ports: clk/rst; in_gdp_md*/phv*/data*/valid* upstream streams with *_alf almost-full flags;
//        pktout_* rebuilt word stream gated by pktout_ready; gdp_ovf sticky overflow; gdp_err_cnt stray drops
module gdp #(
  parameter int MD_AW           = 2,
  parameter int DATA_AW         = 8,
  parameter int DATA_ALF_MARGIN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [255:0]  in_gdp_md,
  input  logic          in_gdp_md_wr,
  output logic          out_gdp_md_alf,
  input  logic [1023:0] in_gdp_phv,
  input  logic          in_gdp_phv_wr,
  output logic          out_gdp_phv_alf,
  input  logic [133:0]  in_gdp_data,
  input  logic          in_gdp_data_wr,
  input  logic          in_gdp_valid_wr,
  input  logic          in_gdp_valid,
  output logic          out_gdp_data_alf,
  output logic [133:0]  pktout_data,
  output logic          pktout_data_wr,
  output logic          pktout_valid_wr,
  output logic          pktout_valid,
  input  logic          pktout_ready,
  output logic          gdp_ovf,
  output logic [15:0]   gdp_err_cnt
);
  localparam int MD_D = 2 ** MD_AW;
  localparam int DATA_D = 2 ** DATA_AW;
  localparam logic [MD_AW:0] MD_FULL = (MD_AW + 1)'(MD_D);
  localparam logic [MD_AW:0] MD_ALF = (MD_AW + 1)'(MD_D - 1);
  localparam logic [DATA_AW:0] DATA_FULL = (DATA_AW + 1)'(DATA_D);
  localparam logic [DATA_AW:0] DATA_ALF = (DATA_AW + 1)'(DATA_D - DATA_ALF_MARGIN);
  typedef enum logic {IDLE_S, SEND_S} state_t;
  state_t r_state, w_state_nxt;
  logic [255:0]  r_md_mem [MD_D];
  logic [1023:0] r_phv_mem [MD_D];
  logic [134:0]  r_d_mem [DATA_D];
  logic [MD_AW-1:0] r_md_wp, r_md_rp, r_phv_wp, r_phv_rp;
  logic [DATA_AW-1:0] r_d_wp, r_d_rp;
  logic [MD_AW:0] r_md_cnt, r_phv_cnt, w_md_cnt_nxt, w_phv_cnt_nxt;
  logic [DATA_AW:0] r_d_cnt, w_d_cnt_nxt;
  logic w_md_we, w_phv_we, w_d_we, w_d_pop, w_hdr_pop, w_err, w_xfer;
  logic [134:0] w_dv;
  logic [133:0] w_dw;
  logic w_d_ne, w_is_head, w_is_tail;
  logic [255:0] r_md_lat, w_md;
  logic [1023:0] r_phv_lat, w_phv;
  logic [7:0] r_widx;
  logic [2:0] w_k;
  logic [127:0] w_pay;
  assign w_md_we = in_gdp_md_wr && r_md_cnt != MD_FULL;
  assign w_phv_we = in_gdp_phv_wr && r_phv_cnt != MD_FULL;
  assign w_d_we = in_gdp_data_wr && r_d_cnt != DATA_FULL;
  assign w_md_cnt_nxt = r_md_cnt + (MD_AW + 1)'(w_md_we) - (MD_AW + 1)'(w_hdr_pop);
  assign w_phv_cnt_nxt = r_phv_cnt + (MD_AW + 1)'(w_phv_we) - (MD_AW + 1)'(w_hdr_pop);
  assign w_d_cnt_nxt = r_d_cnt + (DATA_AW + 1)'(w_d_we) - (DATA_AW + 1)'(w_d_pop);
  assign w_dv = r_d_mem[r_d_rp];
  assign w_dw = w_dv[133:0];
  assign w_d_ne = r_d_cnt != '0;
  assign w_is_head = w_dw[133:132] == 2'b01;
  assign w_is_tail = w_dw[133:132] == 2'b10;
  // The head transfer pops MD/PHV in the same cycle, so it reads the FIFO heads directly.
  assign w_md = r_widx == 8'd0 ? r_md_mem[r_md_rp] : r_md_lat;
  assign w_phv = r_widx == 8'd0 ? r_phv_mem[r_phv_rp] : r_phv_lat;
  assign w_k = 3'(r_widx - 8'd2);
  // Slice k sits at bits [1023-128k -: 128]; shifting by (7-k)*128 brings it to the bottom.
  assign w_pay = r_widx == 8'd0 ? w_md[127:0] :
                 r_widx == 8'd1 ? w_md[255:128] :
                 r_widx < 8'd10 ? 128'(w_phv >> {~w_k, 7'd0}) : w_dw[127:0];
  always_comb begin
    w_state_nxt = r_state;
    w_d_pop = 1'b0;
    w_hdr_pop = 1'b0;
    w_err = 1'b0;
    w_xfer = 1'b0;
    case (r_state)
      IDLE_S: begin
        if (w_d_ne && !w_is_head) begin
          w_d_pop = 1'b1;
          w_err = 1'b1;
        end else if (w_d_ne && r_md_cnt != '0 && r_phv_cnt != '0) begin
          w_state_nxt = SEND_S;
        end
      end
      default: begin
        if (pktout_ready && w_d_ne) begin
          w_xfer = 1'b1;
          w_d_pop = 1'b1;
          w_hdr_pop = r_widx == 8'd0;
          w_state_nxt = w_is_tail ? IDLE_S : SEND_S;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_md_we) r_md_mem[r_md_wp] <= in_gdp_md;
    if (w_phv_we) r_phv_mem[r_phv_wp] <= in_gdp_phv;
    if (w_d_we) r_d_mem[r_d_wp] <= {in_gdp_valid & in_gdp_valid_wr, in_gdp_data};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_S;
      r_md_wp <= '0;
      r_md_rp <= '0;
      r_phv_wp <= '0;
      r_phv_rp <= '0;
      r_d_wp <= '0;
      r_d_rp <= '0;
      r_md_cnt <= '0;
      r_phv_cnt <= '0;
      r_d_cnt <= '0;
      r_md_lat <= '0;
      r_phv_lat <= '0;
      r_widx <= '0;
      out_gdp_md_alf <= 1'b0;
      out_gdp_phv_alf <= 1'b0;
      out_gdp_data_alf <= 1'b0;
      pktout_data <= '0;
      pktout_data_wr <= 1'b0;
      pktout_valid_wr <= 1'b0;
      pktout_valid <= 1'b0;
      gdp_ovf <= 1'b0;
      gdp_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_md_we) r_md_wp <= r_md_wp + MD_AW'(1);
      if (w_phv_we) r_phv_wp <= r_phv_wp + MD_AW'(1);
      if (w_d_we) r_d_wp <= r_d_wp + DATA_AW'(1);
      if (w_hdr_pop) r_md_rp <= r_md_rp + MD_AW'(1);
      if (w_hdr_pop) r_phv_rp <= r_phv_rp + MD_AW'(1);
      if (w_d_pop) r_d_rp <= r_d_rp + DATA_AW'(1);
      r_md_cnt <= w_md_cnt_nxt;
      r_phv_cnt <= w_phv_cnt_nxt;
      r_d_cnt <= w_d_cnt_nxt;
      if (w_hdr_pop) r_md_lat <= w_md;
      if (w_hdr_pop) r_phv_lat <= w_phv;
      if (r_state == IDLE_S && w_state_nxt == SEND_S) r_widx <= '0;
      else if (w_xfer && r_widx != 8'hFF) r_widx <= r_widx + 8'd1;
      out_gdp_md_alf <= w_md_cnt_nxt >= MD_ALF;
      out_gdp_phv_alf <= w_phv_cnt_nxt >= MD_ALF;
      out_gdp_data_alf <= w_d_cnt_nxt >= DATA_ALF;
      if (w_xfer) pktout_data <= {w_dw[133:128], w_pay};
      pktout_data_wr <= w_xfer;
      pktout_valid_wr <= w_xfer && w_is_tail;
      pktout_valid <= w_xfer && w_is_tail && w_dv[134];
      gdp_ovf <= gdp_ovf | (in_gdp_md_wr && !w_md_we) | (in_gdp_phv_wr && !w_phv_we) | (in_gdp_data_wr && !w_d_we);
      if (w_err && gdp_err_cnt != 16'hFFFF) gdp_err_cnt <= gdp_err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_gdp.sv
// tb_gdp: randomized scoreboard bench for the gdp deparser
module tb_gdp;
  logic clk, rst;
  logic [255:0] in_gdp_md;
  logic in_gdp_md_wr, out_gdp_md_alf;
  logic [1023:0] in_gdp_phv;
  logic in_gdp_phv_wr, out_gdp_phv_alf;
  logic [133:0] in_gdp_data;
  logic in_gdp_data_wr, in_gdp_valid_wr, in_gdp_valid, out_gdp_data_alf;
  logic [133:0] pktout_data;
  logic pktout_data_wr, pktout_valid_wr, pktout_valid, pktout_ready;
  logic gdp_ovf;
  logic [15:0] gdp_err_cnt;
  logic rnd_en, rnd_bit, man_ready;
  logic [135:0] exp_q[$];
  int n_chk, n_fail, rx_cnt, exp_err;
  gdp dut (
    .clk(clk), .rst(rst),
    .in_gdp_md(in_gdp_md), .in_gdp_md_wr(in_gdp_md_wr), .out_gdp_md_alf(out_gdp_md_alf),
    .in_gdp_phv(in_gdp_phv), .in_gdp_phv_wr(in_gdp_phv_wr), .out_gdp_phv_alf(out_gdp_phv_alf),
    .in_gdp_data(in_gdp_data), .in_gdp_data_wr(in_gdp_data_wr), .in_gdp_valid_wr(in_gdp_valid_wr),
    .in_gdp_valid(in_gdp_valid), .out_gdp_data_alf(out_gdp_data_alf),
    .pktout_data(pktout_data), .pktout_data_wr(pktout_data_wr), .pktout_valid_wr(pktout_valid_wr),
    .pktout_valid(pktout_valid), .pktout_ready(pktout_ready),
    .gdp_ovf(gdp_ovf), .gdp_err_cnt(gdp_err_cnt)
  );
  assign pktout_ready = rnd_en ? rnd_bit : man_ready;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rnd_bit <= $urandom_range(0, 3) != 0;
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic bound_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask
  task automatic monitor();
    logic [135:0] e;
    forever begin
      @(negedge clk);
      if (!rst && pktout_data_wr) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pktout_unexpected: got %h expected no word", pktout_data);
        end else begin
          e = exp_q.pop_front();
          check("pktout", {pktout_valid_wr, pktout_valid, pktout_data}, e);
          rx_cnt++;
        end
      end
    end
  endtask
  function automatic logic [127:0] slice(input logic [1023:0] phv, input int k);
    return phv[1023 - 128 * k -: 128];
  endfunction
  function automatic logic [1023:0] rnd_phv();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32 * i +: 32] = $urandom;
    return v;
  endfunction
  function automatic logic [255:0] rnd_md();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32 * i +: 32] = $urandom;
    return v;
  endfunction
  task automatic send_pkt(input logic [255:0] md, input logic [1023:0] phv, input int n, input logic v, input logic [127:0] base);
    logic [133:0] w;
    logic [127:0] p;
    int k = 0;
    while ((out_gdp_md_alf || out_gdp_phv_alf || out_gdp_data_alf) && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 2000) bound_fail("alf_wait");
    @(posedge clk);
    #1;
    in_gdp_md = md;
    in_gdp_phv = phv;
    in_gdp_md_wr = 1'b1;
    in_gdp_phv_wr = 1'b1;
    for (int i = 0; i < n; i++) begin
      w[133:132] = i == 0 ? 2'b01 : i == n - 1 ? 2'b10 : 2'b11;
      w[131:128] = 4'($urandom);
      w[127:0] = base + 128'(i);
      in_gdp_data = w;
      in_gdp_data_wr = 1'b1;
      in_gdp_valid_wr = i == n - 1;
      in_gdp_valid = i == n - 1 ? v : 1'($urandom);
      p = i == 0 ? md[127:0] : i == 1 ? md[255:128] : i < 10 ? slice(phv, i - 2) : w[127:0];
      exp_q.push_back({i == n - 1, i == n - 1 && v, w[133:128], p});
      @(posedge clk);
      #1;
      in_gdp_md_wr = 1'b0;
      in_gdp_phv_wr = 1'b0;
    end
    in_gdp_data_wr = 1'b0;
    in_gdp_valid_wr = 1'b0;
    in_gdp_valid = 1'b0;
  endtask
  task automatic put_word(input logic [133:0] w);
    @(posedge clk);
    #1;
    in_gdp_data = w;
    in_gdp_data_wr = 1'b1;
    @(posedge clk);
    #1;
    in_gdp_data_wr = 1'b0;
  endtask
  task automatic wait_drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 3000) begin
      bound_fail(nm);
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
  endtask
  task automatic check_idle_outputs(input string nm);
    check({nm, "_pkt"}, {pktout_data, pktout_data_wr, pktout_valid_wr, pktout_valid}, '0);
    check({nm, "_alf"}, {out_gdp_md_alf, out_gdp_phv_alf, out_gdp_data_alf}, '0);
    check({nm, "_ovf"}, gdp_ovf, '0);
    check({nm, "_err"}, gdp_err_cnt, '0);
  endtask
  initial begin
    logic [255:0] md_a;
    logic [1023:0] phv_a;
    int r0, k;
    rst = 1'b1;
    in_gdp_md = '0; in_gdp_md_wr = 1'b0; in_gdp_phv = '0; in_gdp_phv_wr = 1'b0;
    in_gdp_data = '0; in_gdp_data_wr = 1'b0; in_gdp_valid_wr = 1'b0; in_gdp_valid = 1'b0;
    rnd_en = 1'b0; man_ready = 1'b1;
    n_chk = 0; n_fail = 0; rx_cnt = 0; exp_err = 0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    md_a = {128'hB, 128'hA};
    for (int i = 0; i < 8; i++) phv_a[1023 - 128 * i -: 128] = 128'h1000 + 128'(i);
    send_pkt(md_a, phv_a, 12, 1'b1, 128'hD0);
    wait_drain("drain_12w");
    send_pkt(md_a, phv_a, 4, 1'b0, 128'h40);
    wait_drain("drain_4w");
    r0 = rx_cnt;
    fork
      send_pkt(rnd_md(), rnd_phv(), 12, 1'b1, 128'h700);
      begin
        k = 0;
        while (rx_cnt - r0 < 5 && k < 500) begin
          @(posedge clk);
          k++;
        end
        if (k >= 500) bound_fail("stall_wait");
        #1 man_ready = 1'b0;
        @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          check("stall_no_wr", pktout_data_wr, '0);
        end
        @(posedge clk);
        #1 man_ready = 1'b1;
      end
    join
    wait_drain("drain_stall");
    put_word({2'b11, 4'h0, 128'hBAD});
    exp_err++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stray_err_cnt", gdp_err_cnt, 256'(exp_err));
    send_pkt(rnd_md(), rnd_phv(), 11, 1'b1, 128'h900);
    wait_drain("drain_after_stray");
    rnd_en = 1'b1;
    for (int p = 0; p < 12; p++) begin
      send_pkt(rnd_md(), rnd_phv(), $urandom_range(2, 20), 1'($urandom), {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 2) == 0) begin
        put_word({($urandom_range(0, 1) == 0) ? 2'b11 : 2'b10, 4'($urandom), 128'($urandom)});
        exp_err++;
      end
    end
    wait_drain("drain_random");
    @(negedge clk);
    check("random_err_cnt", gdp_err_cnt, 256'(exp_err));
    check("random_q_empty", 256'(exp_q.size()), '0);
    send_pkt(rnd_md(), rnd_phv(), 40, 1'b1, 128'h5000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("post_reset");
    send_pkt(rnd_md(), rnd_phv(), 14, 1'b1, 128'h6000);
    wait_drain("drain_post_reset");
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 239; i++) begin
      in_gdp_data = {i == 0 ? 2'b01 : 2'b11, 4'h0, 128'(i)};
      in_gdp_data_wr = 1'b1;
      @(posedge clk);
      #1;
    end
    in_gdp_data_wr = 1'b0;
    repeat (2) @(negedge clk);
    check("data_alf_239", out_gdp_data_alf, '0);
    put_word({2'b11, 4'h0, 128'hEF});
    @(negedge clk);
    check("data_alf_240", out_gdp_data_alf, 256'(1));
    check("ovf_before_md", gdp_ovf, '0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1 in_gdp_md = rnd_md();
      in_gdp_md_wr = 1'b1;
      @(posedge clk);
      #1 in_gdp_md_wr = 1'b0;
      @(negedge clk);
      check($sformatf("md_alf_w%0d", i), out_gdp_md_alf, 256'(i >= 3));
      check($sformatf("ovf_w%0d", i), gdp_ovf, 256'(i >= 5));
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("ovf_sticky", gdp_ovf, 256'(1));
    check("no_stray_output", 256'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
